// File: rtl/addsub_mul_bist.sv
// Built-in self-test driver/checker for the pipelined add/sub-multiply unit d = (s ? a+b : a-b) * c.
// Define BIST_FAIL_LOG_EN to build the first-failure capture registers (fail_idx/fail_exp/fail_got).
module addsub_mul_bist #(
  parameter int          DATA_WIDTH  = 8,
  parameter int          DATA_NUM    = 200,
  parameter int          LATENCY     = 2,
  parameter int          PERIOD      = 3,
  parameter int          RESET_EVERY = 20,
  parameter logic [15:0] SEED        = 16'hACE1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  output logic [DATA_WIDTH-1:0]     dut_a,
  output logic [DATA_WIDTH-1:0]     dut_b,
  output logic [DATA_WIDTH-1:0]     dut_c,
  output logic                      dut_s,
  output logic                      dut_reset,
  input  logic [2*DATA_WIDTH-1:0]   dut_d,
  output logic                      busy,
  output logic                      done,
  output logic                      pass,
  output logic [15:0]               vec_count,
  output logic [15:0]               err_count,
  output logic [15:0]               fail_idx,
  output logic [2*DATA_WIDTH-1:0]   fail_exp,
  output logic [2*DATA_WIDTH-1:0]   fail_got
);

  localparam int DW = DATA_WIDTH;
  localparam int PW = 2 * DATA_WIDTH;

  // A slot shorter than the unit's latency could never see a valid result, so it is stretched.
  localparam int          SLOT      = (PERIOD > LATENCY) ? PERIOD : LATENCY + 1;
  localparam logic [15:0] SLOT_LAST = 16'(SLOT - 1);
  localparam logic [15:0] LAST_VEC  = 16'(DATA_NUM - 1);
  localparam logic [15:0] HALF_VEC  = 16'(DATA_NUM / 2);
  localparam logic [15:0] RST_LAST  = 16'(RESET_EVERY - 1);
  localparam logic [15:0] POLY      = 16'hB400;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state;
  logic [15:0] lfsr;
  logic [15:0] slot_cnt;
  logic [15:0] rst_cnt;

  logic [15:0]       lfsr_step;
  logic [15:0]       rst_nxt;
  logic [15:0]       src_l;
  logic [15:0]       src_idx;
  logic              src_rst;
  logic signed [7:0] raw_x;
  logic signed [7:0] raw_y;
  logic [DW-1:0]     nv_a;
  logic [DW-1:0]     nv_b;
  logic [DW-1:0]     nv_c;
  logic              nv_s;
  logic [DW-1:0]     addsub;
  logic [PW-1:0]     exp_d;
  logic              mismatch;
  logic              start_run;
  logic              compare_edge;
  logic              last_vec;
  logic [15:0]       err_inc;

  // Next-vector formation: from SEED when a run starts, otherwise from the stepped LFSR.
  // rst_cnt tracks index mod RESET_EVERY so no divider is needed.
  always_comb begin
    lfsr_step = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? POLY : 16'h0000);
    rst_nxt   = (rst_cnt == RST_LAST) ? 16'h0000 : rst_cnt + 16'd1;

    if (state == RUN) begin
      src_l   = lfsr_step;
      src_idx = vec_count + 16'd1;
      src_rst = (rst_nxt == 16'h0000);
    end else begin
      src_l   = SEED;
      src_idx = 16'h0000;
      src_rst = 1'b1;
    end

    raw_x = src_l[7:0];
    raw_y = src_l[15:8];
    nv_a  = (raw_x > raw_y) ? DW'(raw_x) : DW'(raw_y);
    nv_b  = (raw_x > raw_y) ? DW'(raw_y) : DW'(raw_x);
    nv_c  = (src_idx < HALF_VEC) ? '0 : DW'(src_l[7:0] ^ src_l[15:8]);
    nv_s  = src_l[0] ^ src_l[15];
  end

  // Golden model works off the registered operands, which stay constant for the whole slot.
  always_comb begin
    addsub       = dut_s ? (dut_a + dut_b) : (dut_a - dut_b);
    exp_d        = dut_reset ? '0 : PW'(addsub) * PW'(dut_c);
    mismatch     = (dut_d != exp_d);
    start_run    = start && (state != RUN);
    compare_edge = (state == RUN) && (slot_cnt == SLOT_LAST);
    last_vec     = (vec_count == LAST_VEC);
    err_inc      = (err_count == 16'hFFFF) ? err_count : err_count + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      lfsr      <= SEED;
      slot_cnt  <= '0;
      rst_cnt   <= '0;
      vec_count <= '0;
      err_count <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      dut_a     <= '0;
      dut_b     <= '0;
      dut_c     <= '0;
      dut_s     <= 1'b0;
      dut_reset <= 1'b0;
    end else if (start_run) begin
      state     <= RUN;
      lfsr      <= SEED;
      slot_cnt  <= '0;
      rst_cnt   <= '0;
      vec_count <= '0;
      err_count <= '0;
      busy      <= 1'b1;
      done      <= 1'b0;
      pass      <= 1'b0;
      dut_a     <= nv_a;
      dut_b     <= nv_b;
      dut_c     <= nv_c;
      dut_s     <= nv_s;
      dut_reset <= src_rst;
    end else if (state == RUN) begin
      if (compare_edge) begin
        slot_cnt  <= '0;
        vec_count <= vec_count + 16'd1;
        lfsr      <= lfsr_step;
        rst_cnt   <= rst_nxt;
        if (mismatch) begin
          err_count <= err_inc;
        end
        if (last_vec) begin
          state     <= DONE;
          busy      <= 1'b0;
          done      <= 1'b1;
          pass      <= (err_count == 16'h0000) && !mismatch;
          dut_a     <= '0;
          dut_b     <= '0;
          dut_c     <= '0;
          dut_s     <= 1'b0;
          dut_reset <= 1'b0;
        end else begin
          dut_a     <= nv_a;
          dut_b     <= nv_b;
          dut_c     <= nv_c;
          dut_s     <= nv_s;
          dut_reset <= src_rst;
        end
      end else begin
        slot_cnt <= slot_cnt + 16'd1;
      end
    end
  end

`ifdef BIST_FAIL_LOG_EN
  // Only the first mismatch of a run is kept; err_count==0 marks it.
  always_ff @(posedge clk) begin
    if (reset || start_run) begin
      fail_idx <= '0;
      fail_exp <= '0;
      fail_got <= '0;
    end else if (compare_edge && mismatch && (err_count == 16'h0000)) begin
      fail_idx <= vec_count;
      fail_exp <= exp_d;
      fail_got <= dut_d;
    end
  end
`else
  assign fail_idx = '0;
  assign fail_exp = '0;
  assign fail_got = '0;
`endif

endmodule

// File: tb/tb_addsub_mul_bist.sv
// Self-checking bench for addsub_mul_bist with a behavioural two-stage add/sub-multiply unit beside it.
// Hand-computed vector table plus a reference LFSR model for full-run and corner-case checks.
module tb_addsub_mul_bist;

  logic        clk;
  logic        reset;
  logic        start;
  logic [7:0]  dut_a, dut_b, dut_c;
  logic        dut_s, dut_reset;
  logic [15:0] dut_d;
  logic        busy, done, pass;
  logic [15:0] vec_count, err_count, fail_idx;
  logic [15:0] fail_exp, fail_got;

  int checks = 0;
  int errors = 0;
  int mode   = 0;

  addsub_mul_bist dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .dut_a     (dut_a),
    .dut_b     (dut_b),
    .dut_c     (dut_c),
    .dut_s     (dut_s),
    .dut_reset (dut_reset),
    .dut_d     (dut_d),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .vec_count (vec_count),
    .err_count (err_count),
    .fail_idx  (fail_idx),
    .fail_exp  (fail_exp),
    .fail_got  (fail_got)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural unit: two register stages, synchronous data-path reset.
  logic [7:0]  u_as;
  logic [15:0] u_p1 = '0;
  logic [15:0] u_d  = '0;
  assign u_as = dut_s ? (dut_a + dut_b) : (dut_a - dut_b);
  always @(posedge clk) begin
    if (dut_reset) begin
      u_p1 <= '0;
      u_d  <= '0;
    end else begin
      u_p1 <= {8'h00, u_as} * {8'h00, dut_c};
      u_d  <= u_p1;
    end
  end

  // Fault injection: 1 = output stuck at 0, 2 = d[3] flipped during vector 137.
  assign dut_d = (mode == 1) ? 16'h0000 :
                 ((mode == 2) && (vec_count == 16'd137)) ? (u_d ^ 16'h0008) : u_d;

  typedef struct {
    int         idx;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] c;
    logic       s;
    logic       r;
  } vec_rec_t;

  vec_rec_t    tab [6];
  logic [7:0]  m_a   [0:199];
  logic [7:0]  m_b   [0:199];
  logic [7:0]  m_c   [0:199];
  logic        m_s   [0:199];
  logic        m_r   [0:199];
  logic [15:0] m_exp [0:199];

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  task automatic applyStimulus(input logic do_start, input logic do_reset);
    @(negedge clk);
    start = do_start;
    reset = do_reset;
    @(negedge clk);
    start = 1'b0;
    reset = 1'b0;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_status"}, 32'({busy, done, pass}), 32'h0);
    checkOutput({tag, "_vec_count"}, 32'(vec_count), 32'h0);
    checkOutput({tag, "_err_count"}, 32'(err_count), 32'h0);
    checkOutput({tag, "_operands"}, 32'({dut_a, dut_b, dut_c, dut_s, dut_reset}), 32'h0);
    checkOutput({tag, "_fail_regs"}, {fail_idx, 16'h0} | 32'(fail_exp) | 32'(fail_got), 32'h0);
  endtask

  task automatic buildModel();
    logic [15:0] l;
    logic [7:0]  x, y, as;
    l = 16'hACE1;
    for (int i = 0; i < 200; i++) begin
      x = l[7:0];
      y = l[15:8];
      if ($signed(x) >= $signed(y)) begin
        m_a[i] = x;
        m_b[i] = y;
      end else begin
        m_a[i] = y;
        m_b[i] = x;
      end
      m_c[i]   = (i >= 100) ? (x ^ y) : 8'h00;
      m_s[i]   = l[0] ^ l[15];
      m_r[i]   = ((i % 20) == 0);
      as       = m_s[i] ? (m_a[i] + m_b[i]) : (m_a[i] - m_b[i]);
      m_exp[i] = m_r[i] ? 16'h0000 : ({8'h00, as} * {8'h00, m_c[i]});
      l        = l[0] ? ((l >> 1) ^ 16'hB400) : (l >> 1);
    end
  endtask

  // Call at the first negedge after the start edge; follows the run until done or a cycle bound.
  task automatic runAndCheck(input string tag, input int s1, input int s2, input int chk_n, input int chk_err);
    int          n;
    int          i;
    int          bad_vec;
    int          bad_stat;
    int          rises;
    int          rcyc;
    int          nonmono;
    logic        prev_r;
    logic [15:0] prev_vc;
    n = 0; bad_vec = 0; bad_stat = 0; rises = 0; rcyc = 0; nonmono = 0;
    prev_r = 1'b0; prev_vc = 16'h0;
    while (done !== 1'b1 && n < 1000) begin
      start = (n == s1) || (n == s2);
      i = n / 3;
      if (n < 600) begin
        if (!(busy === 1'b1 && done === 1'b0)) bad_stat++;
        if (dut_a !== m_a[i] || dut_b !== m_b[i] || dut_c !== m_c[i] ||
            dut_s !== m_s[i] || dut_reset !== m_r[i]) bad_vec++;
        for (int k = 0; k < 6; k++) begin
          if (tab[k].idx == i && (n % 3) == 1)
            checkOutput($sformatf("%s_tab_vec%0d", tag, i),
                        32'({dut_a, dut_b, dut_c, dut_s, dut_reset}),
                        32'({tab[k].a, tab[k].b, tab[k].c, tab[k].s, tab[k].r}));
        end
      end
      if (dut_reset === 1'b1 && prev_r !== 1'b1) rises++;
      if (dut_reset === 1'b1) rcyc++;
      prev_r = dut_reset;
      if (vec_count < prev_vc) nonmono++;
      prev_vc = vec_count;
      if (n == chk_n) checkOutput({tag, "_err_mid"}, 32'(err_count), 32'(chk_err));
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    checkOutput({tag, "_done_cycle"}, 32'(n), 32'd600);
    checkOutput({tag, "_vec_drive_errs"}, 32'(bad_vec), 32'd0);
    checkOutput({tag, "_busy_errs"}, 32'(bad_stat), 32'd0);
    checkOutput({tag, "_rst_pulses"}, 32'(rises), 32'd10);
    checkOutput({tag, "_rst_cycles"}, 32'(rcyc), 32'd30);
    checkOutput({tag, "_vec_nonmono"}, 32'(nonmono), 32'd0);
    checkOutput({tag, "_vec_count"}, 32'(vec_count), 32'd200);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int exp_stuck;
    int first_stuck;

    tab[0] = '{0, 8'hE1, 8'hAC, 8'h00, 1'b0, 1'b1};
    tab[1] = '{1, 8'h70, 8'hE2, 8'h00, 1'b1, 1'b0};
    tab[2] = '{2, 8'h71, 8'h38, 8'h00, 1'b0, 1'b0};
    tab[3] = '{3, 8'h38, 8'h9C, 8'h00, 1'b0, 1'b0};
    tab[4] = '{4, 8'h4E, 8'h1C, 8'h00, 1'b0, 1'b0};
    tab[5] = '{5, 8'h27, 8'h0E, 8'h00, 1'b1, 1'b0};
    buildModel();

    exp_stuck   = 0;
    first_stuck = -1;
    for (int i = 100; i < 200; i++) begin
      if ((i % 20) != 0 && m_exp[i] != 16'h0000) begin
        exp_stuck++;
        if (first_stuck < 0) first_stuck = i;
      end
    end

    reset = 1'b1;
    start = 1'b0;
    mode  = 0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    checkAllZero("reset");

    $display("[TB] run A: correct unit");
    applyStimulus(1'b1, 1'b0);
    runAndCheck("runA", -1, -1, -1, 0);
    checkOutput("runA_pass", 32'(pass), 32'd1);
    checkOutput("runA_err_count", 32'(err_count), 32'd0);

    $display("[TB] run B: rerun with start pulses at vectors 10 and 150");
    applyStimulus(1'b1, 1'b0);
    runAndCheck("runB", 30, 450, -1, 0);
    checkOutput("runB_pass", 32'(pass), 32'd1);

    $display("[TB] run C: result stuck at zero");
    mode = 1;
    applyStimulus(1'b1, 1'b0);
    runAndCheck("runC", -1, -1, 300, 0);
    checkOutput("runC_err_count", 32'(err_count), 32'(exp_stuck));
    checkOutput("runC_pass", 32'(pass), 32'd0);
`ifdef BIST_FAIL_LOG_EN
    checkOutput("runC_fail_idx", 32'(fail_idx), 32'(first_stuck));
    checkOutput("runC_fail_exp", 32'(fail_exp), 32'(m_exp[first_stuck]));
    checkOutput("runC_fail_got", 32'(fail_got), 32'h0);
`endif

    $display("[TB] run D: d[3] flipped on vector 137");
    mode = 2;
    applyStimulus(1'b1, 1'b0);
    runAndCheck("runD", -1, -1, -1, 0);
    checkOutput("runD_err_count", 32'(err_count), 32'd1);
    checkOutput("runD_pass", 32'(pass), 32'd0);
`ifdef BIST_FAIL_LOG_EN
    checkOutput("runD_fail_idx", 32'(fail_idx), 32'd137);
    checkOutput("runD_fail_exp", 32'(fail_exp), 32'(m_exp[137]));
    checkOutput("runD_fail_got", 32'(fail_got), 32'(m_exp[137] ^ 16'h0008));
`else
    checkOutput("runD_fail_regs_tied", 32'(fail_idx) | 32'(fail_exp) | 32'(fail_got), 32'h0);
`endif

    $display("[TB] run E: reset during vector 50, then rerun");
    mode = 0;
    applyStimulus(1'b1, 1'b0);
    repeat (150) @(negedge clk);
    checkOutput("runE_busy_before_reset", 32'({busy, done}), 32'h2);
    applyStimulus(1'b0, 1'b1);
    checkAllZero("runE_after_reset");
    applyStimulus(1'b1, 1'b0);
    runAndCheck("runE", -1, -1, -1, 0);
    checkOutput("runE_pass", 32'(pass), 32'd1);
    checkOutput("runE_err_count", 32'(err_count), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/addsub_mul_bist.md
# addsub_mul_bist

Built-in self-test driver/checker for the pipelined, clock-gated add/sub-multiply unit (`d = (s ? a+b : a-b) * c`). It generates pseudo-random operand vectors, drives them into the unit's `a`/`b`/`c`/`s`/`reset` inputs, and checks the returned `d` against an internal golden model. It keeps error statistics and raises `done`/`pass`. It sits beside the unit under test and takes the stimulus/checking role of the gate-level bench into silicon, so post-synthesis and gate-delay runs need only `start` and `done`.

## Interface
- `DATA_WIDTH`, 8: operand width of the unit under test.
- `DATA_NUM`, 200: vectors per run (≥2, ≤65535).
- `LATENCY`, 2: clock edges from the unit's input to a valid `d`.
- `PERIOD`, 3: cycles each vector is held; must be ≥ `LATENCY`+1.
- `RESET_EVERY`, 20: `dut_reset` is asserted on vectors whose index is a multiple of this.
- `SEED`, 16'hACE1: LFSR load value; must be nonzero.

Ports:
- `clk`, in, 1: sole clock; all state updates on the rising edge.
- `reset`, in, 1: synchronous, active-high; returns the block to IDLE.
- `start`, in, 1: one-cycle request to begin a run.
- `dut_a`, `dut_b`, `dut_c`, out, `DATA_WIDTH`: operands to the unit.
- `dut_s`, out, 1: 1 selects add, 0 selects subtract.
- `dut_reset`, out, 1: data-path reset to the unit.
- `dut_d`, in, 2·`DATA_WIDTH`: result from the unit.
- `busy`, out, 1: high in RUN.
- `done`, out, 1: high in DONE.
- `pass`, out, 1: in DONE, high when `err_count`==0.
- `vec_count`, out, 16: number of vectors completed.
- `err_count`, out, 16: number of mismatches; saturates at 16'hFFFF.
- `fail_idx`, out, 16: index of the first failing vector.
- `fail_exp`, out, 2·`DATA_WIDTH`: expected value at the first failure.
- `fail_got`, out, 2·`DATA_WIDTH`: received value at the first failure.

## Operation
- FSM states: IDLE → RUN → DONE.
  - IDLE: `start` moves to RUN.
  - RUN: after vector `DATA_NUM`-1 has been checked, moves to DONE.
  - DONE: `start` moves to RUN (rerun). There is no other exit except `reset`.
- Entering RUN: LFSR loads `SEED`; `vec_count`, `err_count` and the fail registers clear.
- LFSR: 16-bit Galois, mask 16'hB400. It steps once at the end of each slot.
- Vector *i*, formed from LFSR state L:
  - raw values `x`=L[7:0], `y`=L[15:8], compared as signed.
  - `dut_a`=max(`x`,`y`), `dut_b`=min(`x`,`y`).
  - `dut_c`=0 for *i* < `DATA_NUM`/2; otherwise `dut_c`=L[7:0]^L[15:8].
  - `dut_s`=L[0]^L[15].
  - `dut_reset`=1 when *i* mod `RESET_EVERY`==0, else 0.
- Golden model:
  - `addsub` = (`s` ? `a`+`b` : `a`−`b`) truncated to `DATA_WIDTH`.
  - `exp` = unsigned `addsub` × unsigned `c`, 2·`DATA_WIDTH` bits.
  - On reset vectors `exp`=0.
- Mismatch (`dut_d` ≠ `exp`):
  - `err_count` increments (saturating).
  - The first mismatch of a run captures `fail_idx`/`fail_exp`/`fail_got`.
- `start` is ignored while in RUN.
- Reset values:
  - All outputs 0. This includes `dut_*`, so the unit sees `a`=`b`=`c`=0, `s`=0, `dut_reset`=0.
  - State IDLE; LFSR = `SEED`.

## Timing
- `start` sampled high at edge E: `busy` and the vector 0 drive appear after E.
- Each slot is `PERIOD` cycles; `dut_*` outputs are constant across the whole slot.
- `dut_d` is sampled at the edge that ends the slot. That edge also updates the counters and the LFSR and presents the next vector.
- RUN lasts exactly `DATA_NUM`·`PERIOD` cycles.
- `busy` falls and `done` rises after the final compare edge; `pass` is valid in the same cycle.
- `reset` mid-run:
  - Next cycle is IDLE with all outputs 0.
  - No compare occurs on that edge.
  - A later `start` replays the identical sequence.
- `reset` and `start` high together: `reset` wins.

## Configuration
- `BIST_FAIL_LOG_EN` defined: first-failure capture registers are built and `fail_idx`/`fail_exp`/`fail_got` are driven as above.
- Not defined: no capture logic is built; those ports are tied to 0. `err_count` and `pass` are unaffected.

## Test plan
- Correct behavioural unit, `LATENCY`=2, defaults, one `start`:
  - `done` rises 600 cycles after `busy`.
  - `pass`=1, `err_count`=0, `vec_count`=200.
- Vector 0 after `start`:
  - `dut_a`=8'hE1, `dut_b`=8'hAC, `dut_c`=0, `dut_reset`=1.
  - `dut_reset` pulses exactly 10 times, at vectors 0, 20, …, 180, each `PERIOD` cycles wide.
- Unit with `d` stuck at 0:
  - Vectors 0–99 pass.
  - `err_count` equals the count of vectors 100–199 with nonzero `exp` that are not reset vectors; `pass`=0.
- Single-bit flip of `d[3]` during vector 137 only, with `BIST_FAIL_LOG_EN`:
  - `err_count`=1, `fail_idx`=137.
  - `fail_got`=`fail_exp`^16'h0008.
- `reset` pulsed during vector 50, then `start`:
  - All outputs are 0 the cycle after `reset`.
  - The rerun's vector 0 is again `dut_a`=8'hE1, `dut_b`=8'hAC, and the run ends with `pass`=1.
- `start` pulsed at vectors 10 and 150 of a run:
  - No restart; `vec_count` stays monotonic.
  - `done` arrives at cycle 600 as in the first scenario.
